// File: rtl/mem_stage_sl.sv
// MEM stage for an SRAM-like data interface: waits for data_ok, buffers a response
// during a WB stall, drops responses owed to flushed requests, and extracts load data.
module mem_stage_sl #(
  parameter int ES_BUS_W = 144,
  parameter int WS_BUS_W = 169,
  parameter int DISC_W   = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                ws_allowin,
  output logic                ms_allowin,
  input  logic                es_to_ms_valid,
  input  logic [ES_BUS_W-1:0] es_to_ms_bus,
  input  logic                es_req_pending,
  output logic                ms_to_ws_valid,
  output logic [WS_BUS_W-1:0] ms_to_ws_bus,
  input  logic                data_sram_data_ok,
  input  logic [31:0]         data_sram_rdata,
  output logic                ms_discard_busy,
  output logic [4:0]          ms_to_ds_dest,
  output logic [31:0]         ms_to_ds_value,
  output logic                ms_to_ds_loading,
  input  logic                ws_reflush_ms,
  output logic                ms_int,
  output logic                ms_csr,
  output logic                ms_tid
);

  logic                ms_valid_q, ms_valid_d;
  logic [ES_BUS_W-1:0] es_bus_q, es_bus_d;
  logic                buf_valid_q, buf_valid_d;
  logic [31:0]         buf_data_q, buf_data_d;
  logic [DISC_W-1:0]   cnt_q, cnt_d;
  logic [DISC_W+1:0]   cnt_w;

  logic [31:0] pc, alu_result, ld_data, mem_val, final_result;
  logic [4:0]  dest, ld_op;
  logic [16:0] ex_cause;
  logic [13:0] csr_num;
  logic [31:0] csr_wmask;
  logic        gr_we, res_from_mem, csr_rd, csr_we, ertn, rdcntid, mem_req;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        flush, resp_ok, ready_go, ms_wait, drop, capture;

  assign pc           = es_bus_q[31:0];
  assign alu_result   = es_bus_q[63:32];
  assign dest         = es_bus_q[68:64];
  assign gr_we        = es_bus_q[69];
  assign res_from_mem = es_bus_q[70];
  assign ld_op        = es_bus_q[75:71];
  assign ex_cause     = es_bus_q[92:76];
  assign csr_num      = es_bus_q[106:93];
  assign csr_wmask    = es_bus_q[138:107];
  assign csr_rd       = es_bus_q[139];
  assign csr_we       = es_bus_q[140];
  assign ertn         = es_bus_q[141];
  assign rdcntid      = es_bus_q[142];
  assign mem_req      = es_bus_q[143];

  assign flush          = ws_reflush_ms;
  assign resp_ok        = data_sram_data_ok & (cnt_q == '0);
  assign ready_go       = !mem_req | buf_valid_q | resp_ok;
  assign ms_allowin     = !ms_valid_q | (ready_go & ws_allowin);
  assign ms_to_ws_valid = ms_valid_q & ready_go & !flush;
  assign drop           = data_sram_data_ok & (cnt_q != '0);
  assign ms_wait        = ms_valid_q & mem_req & !buf_valid_q & !resp_ok;
  assign capture        = ms_valid_q & mem_req & !buf_valid_q & resp_ok & !ws_allowin & !flush;
  assign ld_data        = buf_valid_q ? buf_data_q : data_sram_rdata;

  always_comb begin
    ld_byte = ld_data[7:0];
    case (alu_result[1:0])
      2'd1:    ld_byte = ld_data[15:8];
      2'd2:    ld_byte = ld_data[23:16];
      2'd3:    ld_byte = ld_data[31:24];
      default: ld_byte = ld_data[7:0];
    endcase
    ld_half = alu_result[1] ? ld_data[31:16] : ld_data[15:0];
    // ld_op[4] marks an explicit word load; an all-zero ld_op is also a word load
    if (ld_op[4])      mem_val = ld_data;
    else if (ld_op[0]) mem_val = {{24{ld_byte[7]}}, ld_byte};
    else if (ld_op[1]) mem_val = {24'd0, ld_byte};
    else if (ld_op[2]) mem_val = {{16{ld_half[15]}}, ld_half};
    else if (ld_op[3]) mem_val = {16'd0, ld_half};
    else               mem_val = ld_data;
    final_result = res_from_mem ? mem_val : alu_result;
  end

  always_comb begin
    ms_valid_d  = ms_valid_q;
    es_bus_d    = es_bus_q;
    buf_valid_d = buf_valid_q;
    buf_data_d  = buf_data_q;
    if (flush)           ms_valid_d = 1'b0;
    else if (ms_allowin) ms_valid_d = es_to_ms_valid;
    if (es_to_ms_valid & ms_allowin) es_bus_d = es_to_ms_bus;
    if (flush | (ms_to_ws_valid & ws_allowin)) begin
      buf_valid_d = 1'b0;
    end else if (capture) begin
      buf_valid_d = 1'b1;
      buf_data_d  = data_sram_rdata;
    end
    // The MS response stays owed on a flush unless consumed this cycle; a data_ok
    // dropped for an older cancelled request therefore leaves it counted.
    cnt_w = (DISC_W+2)'(cnt_q);
    if (flush) cnt_w = cnt_w + (DISC_W+2)'(ms_wait) + (DISC_W+2)'(es_req_pending);
    if (drop)  cnt_w = cnt_w - (DISC_W+2)'(1);
    cnt_d = cnt_w[DISC_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ms_valid_q  <= 1'b0;
      buf_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      ms_valid_q  <= ms_valid_d;
      buf_valid_q <= buf_valid_d;
      cnt_q       <= cnt_d;
      assert (cnt_w[DISC_W+1:DISC_W] == '0);
    end
  end

  always_ff @(posedge clk) begin
    es_bus_q   <= es_bus_d;
    buf_data_q <= buf_data_d;
  end

  assign ms_to_ws_bus = WS_BUS_W'({rdcntid, alu_result, ertn, csr_we, csr_rd, csr_wmask,
                                   csr_num, ex_cause, gr_we, dest, final_result, pc});

  assign ms_discard_busy  = (cnt_q != '0);
  assign ms_to_ds_dest    = (ms_valid_q & gr_we) ? dest : 5'd0;
  assign ms_to_ds_value   = (ms_valid_q & gr_we) ? final_result : 32'd0;
  assign ms_to_ds_loading = ms_valid_q & res_from_mem & !ready_go;
  assign ms_int           = ms_valid_q & (ertn | (|ex_cause));
  assign ms_csr           = ms_valid_q & (csr_we | csr_rd);
  assign ms_tid           = ms_valid_q & rdcntid;

endmodule
